signed_vedic_div_64by32_seq: RTL and testbench
==============================================

Name: signed_vedic_div_64by32_seq

Overview:
Sequential signed divider that inverts the 32x32 signed Vedic multiplier's operation. It takes a 64-bit two's-complement dividend (the multiplier's product width) and a 32-bit signed divisor, and returns a 32-bit quotient and a 32-bit remainder. Arithmetic is radix-2 restoring, one quotient bit per clock, on magnitudes, with sign fix-up at the end. Results use a valid/ready output handshake and serve as the round-trip checker path (a*b/b == a) in the 64-bit datapath.

Parameters:
N, 32, divisor/quotient/remainder width; dividend is 2*N bits. Only N=32 is verified.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  64  signed dividend
b  input  32  signed divisor
busy  output  1  high in every state except IDLE
valid  output  1  result available; held until accepted
out_ready  input  1  consumer accepts the result when valid=1
quotient  output  32  signed quotient, truncated toward zero
remainder  output  32  signed remainder; same sign as a, or zero
div_by_zero  output  1  error flag, qualified by valid
overflow  output  1  error flag, qualified by valid

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. On reset: state=IDLE, busy=0, valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - When start=1, capture sign_q=a[63]^b[31], sign_r=a[63], ma=|a| (64-bit unsigned), mb=|b| (32-bit unsigned).
  - If b==0: set div_by_zero=1, quotient=0, remainder=0, go to DONE.
  - Else if ma[63:32] >= mb (unsigned quotient exceeds 32 bits): set overflow=1, quotient=0, remainder=0, go to DONE.
  - Otherwise: clear both flags, set partial remainder=ma[63:32], shift register=ma[31:0], counter=0, go to CALC.
  - start=0 in IDLE keeps the state unchanged.
- CALC:
  - Each cycle: shift {rem,sh} left by 1; if the 33-bit trial value rem-mb >= 0, take rem=trial and quotient bit=1, else quotient bit=0.
  - Counter increments; after the 32nd iteration go to FIX.
- FIX:
  - uq = unsigned quotient magnitude.
  - If (sign_q=0 and uq > 2^31-1) or (sign_q=1 and uq > 2^31): overflow=1, quotient=0, remainder=0.
  - Otherwise: quotient = sign_q ? -uq : uq; remainder = sign_r ? -rem : rem.
  - Go to DONE.
- DONE:
  - valid=1, and quotient, remainder and flags are stable.
  - On valid&out_ready: return to IDLE, valid=0. Outputs keep their last values.
- Latency: the normal path asserts valid 34 rising edges after the start edge (1 load + 32 CALC + 1 FIX). Error paths assert valid 1 edge after the start edge.
- Input capture: a and b are registered at start; changes to a and b after the start edge have no effect.
- start outside IDLE, including in DONE during the acceptance cycle, is ignored and is not queued.
- Most-negative cases:
  - a = -2^63 gives magnitude 2^63, which is representable as 64-bit unsigned.
  - b = -2^31 gives mb = 2^31.
  - Quotient -2^31 is legal; +2^31 is overflow.
- Reset asserted mid-CALC or in DONE aborts the operation immediately. No valid pulse follows, and the next start behaves normally.
- Subtraction uses a 33-bit compare so a carry out of the shifted remainder is not lost.

Test Plan:
- a=64'd6, b=32'd3 -> quotient=32'h00000002, remainder=0, valid exactly 34 edges after start, flags 0.
- a=64'hFFFFFFFF_FFFFFFFA (-6), b=3 -> quotient=32'hFFFFFFFE; a=7, b=32'hFFFFFFFE (-2) -> quotient=32'hFFFFFFFD, remainder=1; a=-7, b=2 -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF.
- Product round-trip: a=64'hFFFFFFFF_FFFFFFFA (2*-3), b=32'hFFFFFFFD -> quotient=2, remainder=0; a=64'h00000000_00000006, b=32'hFFFFFFFE -> quotient=32'hFFFFFFFD.
- b=0 with any a -> div_by_zero=1, quotient=0, valid 1 edge after start. a=64'h00000001_00000000, b=1 -> overflow=1. a=64'h00000000_80000000, b=1 -> overflow=1 (FIX path). a=64'hFFFFFFFF_80000000, b=1 -> quotient=32'h80000000, no overflow.
- Handshake: hold out_ready=0 for 10 cycles -> valid and data stay stable. Pulse start while busy -> ignored, no second result. Raise out_ready -> valid drops on the next edge.
- Drop rst_n at CALC iteration 15 -> all outputs go to 0 asynchronously. Release reset, start a=64'd100, b=32'd7 -> quotient=14, remainder=2.

Source files
------------

// File: rtl/signed_vedic_div_64by32_seq_if.sv
// Request/result bundle for the sequential signed 2N-by-N divider.
// Latency: none, wiring only.
// Backpressure: valid is held by the slave until the master raises out_ready.
interface signed_vedic_div_64by32_seq_if #(
   parameter int N = 32
);
   logic             start;
   logic [2*N-1:0]   a;
   logic [N-1:0]     b;
   logic             busy;
   logic             valid;
   logic             out_ready;
   logic [N-1:0]     quotient;
   logic [N-1:0]     remainder;
   logic             div_by_zero;
   logic             overflow;

   // Requester / result consumer side
   modport master (
      output start, a, b, out_ready,
      input  busy, valid, quotient, remainder, div_by_zero, overflow
   );

   // Divider side
   modport slave (
      input  start, a, b, out_ready,
      output busy, valid, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/signed_vedic_div_64by32_seq.sv
// Signed 2N/N restoring divider on magnitudes with sign fix-up; quotient truncates toward zero.
// Latency: valid 34 edges after start (load + 32 iterations + fix), 1 edge on div-by-zero / early overflow.
// Backpressure: result held in DONE until out_ready; start is only sampled in IDLE and never queued.
module signed_vedic_div_64by32_seq #(
   parameter int N = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   signed_vedic_div_64by32_seq_if.slave  bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state, state_nxt;
   logic            sign_q, sign_r;
   logic [N-1:0]    mb;
   logic [N-1:0]    rem;
   logic [N-1:0]    sh;
   logic [N-1:0]    quo, rmd;
   logic            dz, ovf;
   logic [CW-1:0]   cnt;

   logic [2*N-1:0]  ma_in;
   logic [N-1:0]    mb_in;
   logic            b_zero;
   logic            pre_ovf;
   logic [N:0]      rem_sh;
   logic            take;
   logic [N-1:0]    diff;
   logic            fix_ovf;
   logic            last_iter;

   // Operand magnitudes, one restoring step, and the signed-range check on the final magnitude
   always_comb begin
      ma_in     = bus.a[2*N-1] ? (~bus.a + 1'b1) : bus.a;
      mb_in     = bus.b[N-1]   ? (~bus.b + 1'b1) : bus.b;
      b_zero    = (bus.b == '0);
      // Upper half already >= divisor means the magnitude quotient needs more than N bits
      pre_ovf   = (ma_in[2*N-1:N] >= mb_in);
      // The shifted remainder can carry into bit N, so compare at N+1 bits
      rem_sh    = {rem, sh[N-1]};
      take      = (rem_sh >= {1'b0, mb});
      // When take is set the true difference is below mb, so the low N bits are exact
      diff      = rem_sh[N-1:0] - mb;
      // -2^(N-1) is representable, +2^(N-1) is not
      fix_ovf   = sign_q ? (sh[N-1] & (|sh[N-2:0])) : sh[N-1];
      last_iter = (cnt == CW'(N - 1));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = (b_zero || pre_ovf) ? DONE : CALC;
         CALC: if (last_iter) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, shift/subtract iterations and result fix-up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         mb     <= '0;
         rem    <= '0;
         sh     <= '0;
         quo    <= '0;
         rmd    <= '0;
         dz     <= 1'b0;
         ovf    <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sign_q <= bus.a[2*N-1] ^ bus.b[N-1];
                  sign_r <= bus.a[2*N-1];
                  mb     <= mb_in;
                  cnt    <= '0;
                  if (b_zero) begin
                     dz  <= 1'b1;
                     ovf <= 1'b0;
                     quo <= '0;
                     rmd <= '0;
                  end else if (pre_ovf) begin
                     dz  <= 1'b0;
                     ovf <= 1'b1;
                     quo <= '0;
                     rmd <= '0;
                  end else begin
                     dz  <= 1'b0;
                     ovf <= 1'b0;
                     rem <= ma_in[2*N-1:N];
                     sh  <= ma_in[N-1:0];
                  end
               end
            end
            CALC: begin
               // Dividend bits leave sh at the top while quotient bits enter at the bottom
               rem <= take ? diff : rem_sh[N-1:0];
               sh  <= {sh[N-2:0], take};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (fix_ovf) begin
                  ovf <= 1'b1;
                  quo <= '0;
                  rmd <= '0;
               end else begin
                  quo <= sign_q ? (~sh + 1'b1) : sh;
                  rmd <= sign_r ? (~rem + 1'b1) : rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.valid       = (state == DONE);
   assign bus.quotient    = quo;
   assign bus.remainder   = rmd;
   assign bus.div_by_zero = dz;
   assign bus.overflow    = ovf;
endmodule

// File: tb/tb_signed_vedic_div_64by32_seq.sv
// Bench for the sequential signed 64/32 divider: directed table, random vs arithmetic model,
// handshake hold/ignore sequences and asynchronous reset abort.
module tb_signed_vedic_div_64by32_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   signed_vedic_div_64by32_seq_if #(.N(32)) dif ();

   signed_vedic_div_64by32_seq #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
      int          lat;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Plain signed-division reference: |a| / |b| in 64-bit unsigned, then range and sign rules
   function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output logic ov, output int lat);
      logic [63:0] ma, mb, uq, ur, t;
      logic        neg;
      q = '0; r = '0; dz = 1'b0; ov = 1'b0; lat = 1;
      ma = a[63] ? (64'd0 - a) : a;
      mb = {32'd0, (b[31] ? (32'd0 - b) : b)};
      if (b == 32'd0) begin
         dz = 1'b1;
      end else begin
         uq  = ma / mb;
         ur  = ma % mb;
         neg = a[63] ^ b[31];
         if (uq > 64'hFFFF_FFFF) begin
            ov = 1'b1;
         end else begin
            lat = 34;
            if (uq > (neg ? 64'h8000_0000 : 64'h7FFF_FFFF)) begin
               ov = 1'b1;
            end else begin
               t = neg ? (64'd0 - uq) : uq;
               q = t[31:0];
               t = a[63] ? (64'd0 - ur) : ur;
               r = t[31:0];
            end
         end
      end
   endfunction

   // One full transaction: start, scramble operands, wait for valid, check, accept
   task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input logic eov, input int elat);
      int lat;
      @(negedge clk);
      dif.a = a; dif.b = b; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start = 1'b0;
      dif.a = ~a; dif.b = ~b;
      lat = 1;
      while (dif.valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"},   64'(lat),             64'(elat));
      chk({tag, " quotient"},  64'(dif.quotient),    64'(eq));
      chk({tag, " remainder"}, 64'(dif.remainder),   64'(er));
      chk({tag, " dz"},        64'(dif.div_by_zero), 64'(edz));
      chk({tag, " ovf"},       64'(dif.overflow),    64'(eov));
      dif.out_ready = 1'b1;
      @(posedge clk); #1;
      dif.out_ready = 1'b0;
   endtask

   task automatic run_model(input string tag, input logic [63:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      logic dz, ov;
      int lat;
      model(a, b, q, r, dz, ov, lat);
      run_op(tag, a, b, q, r, dz, ov, lat);
   endtask

   initial begin
      logic [63:0] ra;
      logic [31:0] rb, rq;
      logic        stable, seen;

      vt[0]  = '{64'd6,                    32'd3,          32'd2,          32'd0,          1'b0, 1'b0, 34};
      vt[1]  = '{64'hFFFFFFFF_FFFFFFFA,    32'd3,          32'hFFFFFFFE,   32'd0,          1'b0, 1'b0, 34};
      vt[2]  = '{64'd7,                    32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 34};
      vt[3]  = '{64'hFFFFFFFF_FFFFFFF9,    32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 34};
      vt[4]  = '{64'hFFFFFFFF_FFFFFFFA,    32'hFFFFFFFD,   32'd2,          32'd0,          1'b0, 1'b0, 34};
      vt[5]  = '{64'h00000000_00000006,    32'hFFFFFFFE,   32'hFFFFFFFD,   32'd0,          1'b0, 1'b0, 34};
      vt[6]  = '{64'h12345678_9ABCDEF0,    32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 1};
      vt[7]  = '{64'h00000001_00000000,    32'd1,          32'd0,          32'd0,          1'b0, 1'b1, 1};
      vt[8]  = '{64'h00000000_80000000,    32'd1,          32'd0,          32'd0,          1'b0, 1'b1, 34};
      vt[9]  = '{64'hFFFFFFFF_80000000,    32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0, 34};
      vt[10] = '{64'd100,                  32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 34};
      vt[11] = '{64'h80000000_00000000,    32'h80000000,   32'd0,          32'd0,          1'b0, 1'b1, 1};
      vt[12] = '{64'hC0000000_00000000,    32'h80000000,   32'd0,          32'd0,          1'b0, 1'b1, 34};
      vt[13] = '{64'h40000000_00000000,    32'h80000000,   32'h80000000,   32'd0,          1'b0, 1'b0, 34};
      vt[14] = '{64'hFFFFFFFF_FFFFFFFF,    32'd5,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b0, 34};
      vt[15] = '{64'h7FFFFFFF_FFFFFFFF,    32'h7FFFFFFF,   32'd0,          32'd0,          1'b0, 1'b1, 1};

      dif.start = 1'b0; dif.a = '0; dif.b = '0; dif.out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst q/r",   {dif.quotient, dif.remainder}, 64'd0);
      chk("rst flags", 64'({dif.busy, dif.valid, dif.div_by_zero, dif.overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 16; i++)
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].ov, vt[i].lat);

      // Random operands with random arithmetic shifts to mix in-range and overflow cases
      for (int i = 0; i < 120; i++) begin
         ra = {$urandom, $urandom};
         ra = $signed(ra) >>> $urandom_range(0, 63);
         rb = $urandom;
         if ($urandom_range(0, 2) == 0) rb = $signed(rb) >>> $urandom_range(0, 31);
         if ($urandom_range(0, 19) == 0) rb = '0;
         run_model($sformatf("rnd%0d", i), ra, rb);
      end

      // Product round-trips: (q*b)/b must give q back unless it is the +2^31 case
      for (int i = 0; i < 40; i++) begin
         rq = $urandom;
         rb = $urandom;
         if (rb == '0) rb = 32'd1;
         ra = 64'($signed(rq)) * 64'($signed(rb));
         run_model($sformatf("trip%0d", i), ra, rb);
      end

      // Handshake: start ignored while busy and in DONE, result held without out_ready
      @(negedge clk);
      dif.a = 64'd6; dif.b = 32'd3; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start = 1'b0;
      chk("hs busy", 64'(dif.busy), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      dif.a = 64'd100; dif.b = 32'd7; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start = 1'b0;
      for (int k = 0; k < 60 && dif.valid !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      chk("hs valid", 64'(dif.valid), 64'd1);
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 4) dif.start = 1'b1;
         @(posedge clk); #1;
         dif.start = 1'b0;
         if (dif.valid !== 1'b1 || dif.quotient !== 32'd2 || dif.remainder !== 32'd0) stable = 1'b0;
      end
      chk("hs hold stable", 64'(stable), 64'd1);
      dif.out_ready = 1'b1; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.out_ready = 1'b0; dif.start = 1'b0;
      chk("hs valid drop", 64'(dif.valid), 64'd0);
      chk("hs idle after accept", 64'(dif.busy), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.valid !== 1'b0 || dif.busy !== 1'b0) seen = 1'b1;
      end
      chk("hs no second result", 64'(seen), 64'd0);

      // Asynchronous reset at CALC iteration 15
      run_op("pre-rst", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);
      @(negedge clk);
      dif.a = 64'd6; dif.b = 32'd3; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      chk("rst mid busy before", 64'(dif.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst mid q/r", {dif.quotient, dif.remainder}, 64'd0);
      chk("rst mid flags", 64'({dif.busy, dif.valid, dif.div_by_zero, dif.overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dif.valid !== 1'b0) seen = 1'b1;
      end
      chk("rst mid no valid", 64'(seen), 64'd0);
      run_op("post-rst", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);

      // Reset while a result is waiting in DONE
      @(negedge clk);
      dif.a = 64'd9; dif.b = 32'd0; dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start = 1'b0;
      chk("done valid", 64'(dif.valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("done rst flags", 64'({dif.busy, dif.valid, dif.div_by_zero, dif.overflow}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post-done-rst", 64'hFFFFFFFF_FFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
